// File: rtl/kbdmk1_pkg.sv
// Shared constants and event type for the Mk1 keyboard event controller.
package kbdmk1_pkg;

    localparam int unsigned NUM_KEYS_DEFAULT = 80;
    localparam int unsigned EV_MAKE          = 0;

    // Packed MSB-first: the make flag lands on ev_data[0], the scancode on ev_data[1:7].
    typedef struct packed {
        logic       make;
        logic [6:0] code;
    } kbd_event_t;

    function automatic kbd_event_t make_event(input logic make, input logic [6:0] code);
        kbd_event_t ev;
        ev.make = make;
        ev.code = code;
        return ev;
    endfunction

endpackage

// File: rtl/kbdmk1_events_if.sv
// Valid/ready event channel between the key-event controller and its consumer.
interface kbdmk1_events_if;

    logic       ev_valid;
    logic       ev_ready;
    logic [0:7] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);

endinterface

// File: rtl/kbdmk1_evfifo.sv
// Synchronous event FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module kbdmk1_evfifo
    import kbdmk1_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  kbd_event_t wdata_i,
    output kbd_event_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    kbd_event_t    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero when empty so the output is defined without resetting storage.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/kbdmk1_events.sv
// Key-event controller: tracks the per-key state map and queues make/break events.
// Optional per-key two-sample debounce is enabled by defining KBDMK1_EVENTS_DEBOUNCE_EN.
module kbdmk1_events
    import kbdmk1_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = NUM_KEYS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [0:6]           kbd_scancode,
    input  logic                 kbd_keypress,
    input  logic                 kbd_strobe,
    kbdmk1_events_if.master      ev,
    output logic [0:NUM_KEYS-1]  key_state,
    output logic                 ev_overflow,
    input  logic                 ovf_clear
);

    logic [0:NUM_KEYS-1] key_q, key_d;
    logic                ovf_q, ovf_d;
    logic [6:0]          code;
    logic                in_range;
    logic                differ;
    logic                accept;
    logic                push, pop, drop;
    logic                fifo_full, fifo_empty;
    kbd_event_t          push_ev, head_ev;

`ifdef KBDMK1_EVENTS_DEBOUNCE_EN
    logic [0:NUM_KEYS-1] cand_q, cand_d;
`endif

    assign code     = kbd_scancode;
    assign in_range = (32'(code) < NUM_KEYS);
    assign differ   = in_range && (kbd_keypress != key_q[code]);

    always_comb begin
        key_d  = key_q;
        accept = 1'b0;
`ifdef KBDMK1_EVENTS_DEBOUNCE_EN
        cand_d = cand_q;
        if (kbd_strobe && in_range) begin
            if (!differ) begin
                cand_d[code] = 1'b0;
            end else if (!cand_q[code]) begin
                cand_d[code] = 1'b1;
            end else begin
                cand_d[code] = 1'b0;
                accept       = 1'b1;
            end
        end
`else
        accept = kbd_strobe && differ;
`endif
        if (accept) key_d[code] = kbd_keypress;
    end

    assign push    = accept;
    assign push_ev = make_event(kbd_keypress, code);
    assign pop     = ev.ev_valid && ev.ev_ready;
    // key_state still moves on a dropped push; only the event is lost.
    assign drop    = push && fifo_full && !pop;
    assign ovf_d   = drop || (ovf_q && !ovf_clear);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q  <= '0;
            ovf_q  <= 1'b0;
`ifdef KBDMK1_EVENTS_DEBOUNCE_EN
            cand_q <= '0;
`endif
        end else begin
            key_q  <= key_d;
            ovf_q  <= ovf_d;
`ifdef KBDMK1_EVENTS_DEBOUNCE_EN
            cand_q <= cand_d;
`endif
        end
    end

    kbdmk1_evfifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_evfifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_ev),
        .rdata_o (head_ev),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_data  = head_ev;
    assign key_state   = key_q;
    assign ev_overflow = ovf_q;

endmodule

// File: tb/tb_kbdmk1_events.sv
// Directed self-checking bench for kbdmk1_events (default and debounce builds).
module tb_kbdmk1_events;

    localparam int STROBE_GAP = 175;
`ifdef KBDMK1_EVENTS_DEBOUNCE_EN
    localparam int NSTB = 2;
`else
    localparam int NSTB = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:6]  kbd_scancode = '0;
    logic        kbd_keypress = 1'b0;
    logic        kbd_strobe = 1'b0;
    logic [0:79] key_state;
    logic        ev_overflow;
    logic        ovf_clear = 1'b0;
    logic [0:79] exp_keys = '0;
    int          checks = 0;
    int          errors = 0;

    kbdmk1_events_if ev_if ();

    kbdmk1_events dut (
        .clk          (clk),
        .reset        (reset),
        .kbd_scancode (kbd_scancode),
        .kbd_keypress (kbd_keypress),
        .kbd_strobe   (kbd_strobe),
        .ev           (ev_if),
        .key_state    (key_state),
        .ev_overflow  (ev_overflow),
        .ovf_clear    (ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic strobe(input int k, input bit s, input bit rdy, input bit clr);
        repeat (STROBE_GAP) @(posedge clk);
        #1;
        kbd_scancode    = 7'(k);
        kbd_keypress    = s;
        kbd_strobe      = 1'b1;
        ev_if.ev_ready  = rdy;
        ovf_clear       = clr;
        @(posedge clk);
        #1;
        kbd_strobe      = 1'b0;
        ev_if.ev_ready  = 1'b0;
        ovf_clear       = 1'b0;
    endtask

    // Enough identical samples for the build's acceptance rule; ready/clear ride the last one.
    task automatic accept(input int k, input bit s, input bit rdy, input bit clr);
        for (int i = 0; i < NSTB - 1; i++) strobe(k, s, 1'b0, 1'b0);
        strobe(k, s, rdy, clr);
        exp_keys[k] = s;
    endtask

    task automatic pop_expect(input logic [7:0] exp, input string name);
        checks++;
        if (ev_if.ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: got %b want 1", name, ev_if.ev_valid);
        end
        checks++;
        if (ev_if.ev_data !== exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, ev_if.ev_data, exp);
        end
        ev_if.ev_ready = 1'b1;
        @(posedge clk);
        #1;
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic expect_empty(input string name);
        checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s empty: got valid %b want 0", name, ev_if.ev_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_empty("reset");
        checks++;
        if (ev_if.ev_data !== 8'h00) begin
            errors++; $display("FAIL reset data: got %h want 00", ev_if.ev_data);
        end
        checks++;
        if (key_state !== 80'h0) begin
            errors++; $display("FAIL reset keys: got %h want 0", key_state);
        end
        checks++;
        if (ev_overflow !== 1'b0) begin
            errors++; $display("FAIL reset ovf: got %b want 0", ev_overflow);
        end
        reset = 1'b0;
    endtask

    task automatic test_debounce();
`ifdef KBDMK1_EVENTS_DEBOUNCE_EN
        strobe(18, 1'b1, 1'b0, 1'b0);
        expect_empty("deb first sample");
        checks++;
        if (key_state[18] !== 1'b0) begin
            errors++; $display("FAIL deb key18 early: got %b want 0", key_state[18]);
        end
        strobe(18, 1'b1, 1'b0, 1'b0);
        exp_keys[18] = 1'b1;
        checks++;
        if (key_state[18] !== 1'b1) begin
            errors++; $display("FAIL deb key18: got %b want 1", key_state[18]);
        end
        pop_expect(8'h92, "deb key18 make");
        expect_empty("deb drained");
        strobe(5, 1'b1, 1'b0, 1'b0);
        strobe(5, 1'b0, 1'b0, 1'b0);
        strobe(5, 1'b1, 1'b0, 1'b0);
        expect_empty("deb bounce key5");
        checks++;
        if (key_state[5] !== 1'b0) begin
            errors++; $display("FAIL deb key5: got %b want 0", key_state[5]);
        end
        strobe(5, 1'b0, 1'b0, 1'b0);
`else
        strobe(18, 1'b1, 1'b0, 1'b0);
        exp_keys[18] = 1'b1;
        checks++;
        if (key_state[18] !== 1'b1) begin
            errors++; $display("FAIL key18: got %b want 1", key_state[18]);
        end
        pop_expect(8'h92, "key18 make");
        expect_empty("key18 drained");
        strobe(5, 1'b0, 1'b0, 1'b0);
        expect_empty("key5 no change");
        strobe(5, 1'b1, 1'b0, 1'b0);
        pop_expect(8'h85, "key5 make");
        strobe(5, 1'b0, 1'b0, 1'b0);
        pop_expect(8'h05, "key5 break");
        expect_empty("key5 drained");
`endif
    endtask

    task automatic test_make_break();
        accept(79, 1'b1, 1'b0, 1'b0);
        checks++;
        if (key_state[79] !== 1'b1) begin
            errors++; $display("FAIL mb key79 down: got %b want 1", key_state[79]);
        end
        accept(79, 1'b0, 1'b0, 1'b0);
        pop_expect(8'hCF, "mb make");
        pop_expect(8'h4F, "mb break");
        expect_empty("mb drained");
        checks++;
        if (key_state !== exp_keys) begin
            errors++; $display("FAIL mb keys: got %h want %h", key_state, exp_keys);
        end
    endtask

    task automatic test_out_of_range();
        strobe(85, 1'b1, 1'b0, 1'b0);
        strobe(85, 1'b1, 1'b0, 1'b0);
        strobe(80, 1'b1, 1'b0, 1'b0);
        strobe(80, 1'b1, 1'b0, 1'b0);
        expect_empty("oor");
        checks++;
        if (key_state !== exp_keys) begin
            errors++; $display("FAIL oor keys: got %h want %h", key_state, exp_keys);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] head;
        for (int i = 0; i < 16; i++) accept(20 + i, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf at 16: got %b want 0", ev_overflow);
        end
        accept(36, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf at 17: got %b want 1", ev_overflow);
        end
        checks++;
        if (key_state !== exp_keys) begin
            errors++; $display("FAIL ovf keys: got %h want %h", key_state, exp_keys);
        end
        head = ev_if.ev_data;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ev_if.ev_data !== 8'h94 || head !== 8'h94) begin
            errors++; $display("FAIL ovf head hold: got %h/%h want 94", head, ev_if.ev_data);
        end
        // Clear coinciding with another dropped push must leave the flag set.
        accept(38, 1'b1, 1'b0, 1'b1);
        checks++;
        if (ev_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf clear+drop: got %b want 1", ev_overflow);
        end
        @(posedge clk);
        #1;
        ovf_clear = 1'b1;
        @(posedge clk);
        #1;
        ovf_clear = 1'b0;
        checks++;
        if (ev_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf clear: got %b want 0", ev_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        accept(37, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ev_overflow !== 1'b0) begin
            errors++; $display("FAIL fpp ovf: got %b want 0", ev_overflow);
        end
        for (int i = 21; i < 36; i++) pop_expect(8'h80 | 8'(i), "fpp drain");
        pop_expect(8'hA5, "fpp pushed key37");
        expect_empty("fpp drained");
    endtask

    task automatic test_reset_mid();
        accept(40, 1'b1, 1'b0, 1'b0);
        accept(41, 1'b1, 1'b0, 1'b0);
        accept(42, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ev_if.ev_valid !== 1'b1) begin
            errors++; $display("FAIL rst queued: got valid %b want 1", ev_if.ev_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_empty("rst async");
        checks++;
        if (key_state !== 80'h0) begin
            errors++; $display("FAIL rst keys: got %h want 0", key_state);
        end
        checks++;
        if (ev_if.ev_data !== 8'h00) begin
            errors++; $display("FAIL rst data: got %h want 00", ev_if.ev_data);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_keys = '0;
        accept(40, 1'b1, 1'b0, 1'b0);
        checks++;
        if (key_state !== exp_keys) begin
            errors++; $display("FAIL rst rehold keys: got %h want %h", key_state, exp_keys);
        end
        pop_expect(8'hA8, "rst rehold make");
        expect_empty("rst drained");
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        test_reset();
        test_debounce();
        test_make_break();
        test_out_of_range();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
